// File: rtl/dbf_scan_seq.sv
// Per-scan-line sequencer for the DBF channel array: LUT load, transmit window,
// receive window with dynamic-focus zone stepping, then an inter-line gap.
module dbf_scan_seq #(
  parameter int ADDR_WD   = 8,
  parameter int LUT_DEPTH = 256,
  parameter int TX_LEN    = 64,
  parameter int RX_LEN    = 4096,
  parameter int ZONE_LEN  = 256,
  parameter int LINE_GAP  = 16,
  parameter int NUM_LINES = 128,
  parameter int CNT_WD    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               abort,
  output logic               tx_en,
  output logic               start,
  output logic [ADDR_WD-1:0] dbf_lut_addr,
  output logic               dbf_lut_we,
  output logic [CNT_WD-1:0]  line_idx,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_TX   = 3'd2;
  localparam logic [2:0] S_RX   = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [ADDR_WD-1:0] ADDR_MAX  = ADDR_WD'(LUT_DEPTH - 1);
  localparam logic [CNT_WD-1:0]  LOAD_LAST = CNT_WD'(LUT_DEPTH - 1);
  localparam logic [CNT_WD-1:0]  TX_LAST   = CNT_WD'(TX_LEN - 1);
  localparam logic [CNT_WD-1:0]  RX_LAST   = CNT_WD'(RX_LEN - 1);
  localparam logic [CNT_WD-1:0]  ZONE_LAST = CNT_WD'(ZONE_LEN - 1);
  localparam logic [CNT_WD-1:0]  GAP_LAST  = CNT_WD'(LINE_GAP - 1);
  localparam logic [CNT_WD-1:0]  LINE_LAST = CNT_WD'(NUM_LINES - 1);

  logic [2:0]        state;
  logic [CNT_WD-1:0] cnt;   // cycles spent in the current state
  logic [CNT_WD-1:0] zcnt;  // receive samples within the current focal zone

  // Outputs are driven alongside the state transition so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      zcnt         <= '0;
      tx_en        <= 1'b0;
      start        <= 1'b0;
      dbf_lut_addr <= '0;
      dbf_lut_we   <= 1'b0;
      line_idx     <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort && state != S_IDLE) begin
        state        <= S_IDLE;
        cnt          <= '0;
        zcnt         <= '0;
        tx_en        <= 1'b0;
        start        <= 1'b0;
        dbf_lut_addr <= '0;
        dbf_lut_we   <= 1'b0;
        line_idx     <= '0;
        busy         <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm && !abort) begin
              state        <= S_LOAD;
              cnt          <= '0;
              dbf_lut_we   <= 1'b1;
              dbf_lut_addr <= '0;
              busy         <= 1'b1;
            end
          end
          S_LOAD: begin
            if (cnt == LOAD_LAST) begin
              state        <= S_TX;
              cnt          <= '0;
              dbf_lut_we   <= 1'b0;
              dbf_lut_addr <= '0;
              tx_en        <= 1'b1;
            end else begin
              cnt          <= cnt + 1'b1;
              dbf_lut_addr <= dbf_lut_addr + 1'b1;
            end
          end
          S_TX: begin
            if (cnt == TX_LAST) begin
              state        <= S_RX;
              cnt          <= '0;
              zcnt         <= '0;
              tx_en        <= 1'b0;
              start        <= 1'b1;
              dbf_lut_addr <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RX: begin
            if (cnt == RX_LAST) begin
              state        <= S_GAP;
              cnt          <= '0;
              zcnt         <= '0;
              start        <= 1'b0;
              dbf_lut_addr <= '0;
            end else begin
              cnt <= cnt + 1'b1;
              // Zone address holds at the last LUT entry rather than wrapping.
              if (zcnt == ZONE_LAST) begin
                zcnt <= '0;
                if (dbf_lut_addr != ADDR_MAX) dbf_lut_addr <= dbf_lut_addr + 1'b1;
              end else begin
                zcnt <= zcnt + 1'b1;
              end
            end
          end
          S_GAP: begin
            if (cnt == GAP_LAST) begin
              cnt <= '0;
              if (line_idx != LINE_LAST) begin
                state        <= S_LOAD;
                line_idx     <= line_idx + 1'b1;
                dbf_lut_we   <= 1'b1;
                dbf_lut_addr <= '0;
              end else begin
                state      <= S_IDLE;
                line_idx   <= '0;
                busy       <= 1'b0;
                frame_done <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state        <= S_IDLE;
            cnt          <= '0;
            zcnt         <= '0;
            tx_en        <= 1'b0;
            start        <= 1'b0;
            dbf_lut_addr <= '0;
            dbf_lut_we   <= 1'b0;
            line_idx     <= '0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dbf_scan_seq.sv
// Bench for dbf_scan_seq: three instances (zone length 2, zone length 3, long RX)
// compared every cycle against a frame-time arithmetic model.
module tb_dbf_scan_seq;
  localparam int LD = 4, TXL = 3, GPL = 2, NL = 2;
  localparam int RXA [3] = '{8, 8, 20};
  localparam int ZLA [3] = '{2, 3, 2};

  typedef struct packed {
    logic        tx;
    logic        st;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] line;
    logic        busy;
    logic        fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, arm, abort;
  logic        tx_en [3];
  logic        start [3];
  logic        we    [3];
  logic [7:0]  addr  [3];
  logic [15:0] line  [3];
  logic        busy  [3];
  logic        fd    [3];

  int errors = 0;
  int checks = 0;
  int t [3];

  always #5 clk = ~clk;

  dbf_scan_seq #(.ADDR_WD(8), .LUT_DEPTH(LD), .TX_LEN(TXL), .RX_LEN(8), .ZONE_LEN(2),
                 .LINE_GAP(GPL), .NUM_LINES(NL), .CNT_WD(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .tx_en(tx_en[0]), .start(start[0]),
    .dbf_lut_addr(addr[0]), .dbf_lut_we(we[0]), .line_idx(line[0]), .busy(busy[0]),
    .frame_done(fd[0]));
  dbf_scan_seq #(.ADDR_WD(8), .LUT_DEPTH(LD), .TX_LEN(TXL), .RX_LEN(8), .ZONE_LEN(3),
                 .LINE_GAP(GPL), .NUM_LINES(NL), .CNT_WD(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .tx_en(tx_en[1]), .start(start[1]),
    .dbf_lut_addr(addr[1]), .dbf_lut_we(we[1]), .line_idx(line[1]), .busy(busy[1]),
    .frame_done(fd[1]));
  dbf_scan_seq #(.ADDR_WD(8), .LUT_DEPTH(LD), .TX_LEN(TXL), .RX_LEN(20), .ZONE_LEN(2),
                 .LINE_GAP(GPL), .NUM_LINES(NL), .CNT_WD(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .tx_en(tx_en[2]), .start(start[2]),
    .dbf_lut_addr(addr[2]), .dbf_lut_we(we[2]), .line_idx(line[2]), .busy(busy[2]),
    .frame_done(fd[2]));

  function automatic int frame_len(input int k);
    return NL * (LD + TXL + RXA[k] + GPL);
  endfunction

  // t = cycles since the arm edge (0 = idle); outputs follow from line period arithmetic.
  function automatic exp_t model(input int tt, input int rx, input int zl);
    exp_t e;
    int p, f, pos, z;
    e = '0;
    p = LD + TXL + rx + GPL;
    f = NL * p;
    if (tt == f + 1) e.fd = 1'b1;
    else if (tt >= 1 && tt <= f) begin
      e.busy = 1'b1;
      e.line = 16'((tt - 1) / p);
      pos = (tt - 1) % p;
      if (pos < LD) begin
        e.we = 1'b1;
        e.addr = 8'(pos);
      end else if (pos < LD + TXL) begin
        e.tx = 1'b1;
      end else if (pos < LD + TXL + rx) begin
        e.st = 1'b1;
        z = (pos - LD - TXL) / zl;
        e.addr = 8'((z > LD - 1) ? LD - 1 : z);
      end
    end
    return e;
  endfunction

  task automatic check(input string tag, input int k, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s dut%0d t=%0d observed=%0d expected=%0d", tag, k, t[k], obs, expv);
    end
  endtask

  task automatic check_all();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e = model(t[k], RXA[k], ZLA[k]);
      check("tx_en", k, int'(tx_en[k]), int'(e.tx));
      check("start", k, int'(start[k]), int'(e.st));
      check("lut_we", k, int'(we[k]), int'(e.we));
      check("lut_addr", k, int'(addr[k]), int'(e.addr));
      check("line_idx", k, int'(line[k]), int'(e.line));
      check("busy", k, int'(busy[k]), int'(e.busy));
      check("frame_done", k, int'(fd[k]), int'(e.fd));
    end
  endtask

  task automatic step();
    bit idle;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      idle = (t[k] == 0) || (t[k] == frame_len(k) + 1);
      if (abort && !idle) t[k] = 0;
      else if (idle) t[k] = (arm && !abort) ? 1 : 0;
      else t[k] = t[k] + 1;
    end
    #1;
    check_all();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    arm = 1'b0;
    abort = 1'b0;
    while ((busy[0] || busy[1] || busy[2] || t[0] != 0 || t[1] != 0 || t[2] != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL idle_timeout observed=%0d expected<%0d", n, budget);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    t = '{0, 0, 0};
    #2;
    check_all();
    #10 rst_n = 1'b1;
    step();
    step();

    // Full frame with the arm edge as cycle 0, plus stray arms while busy.
    repeat ($urandom_range(0, 3)) step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      arm = (c == 3 || c == 20 || (c < 34 && $urandom_range(0, 4) == 0));
      step();
    end
    run_until_idle(100);

    // Abort in RX, then restart from line 0.
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (9) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat ($urandom_range(1, 4)) step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (12) step();
    run_until_idle(100);

    // arm and abort together in IDLE.
    arm = 1'b1;
    abort = 1'b1;
    step();
    step();
    arm = 1'b0;
    abort = 1'b0;
    step();

    // Asynchronous reset in the middle of TX.
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    t = '{0, 0, 0};
    check_all();
    #3 rst_n = 1'b1;
    repeat (3) step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    run_until_idle(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
